// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the MEM-stage access unit: FSM state encoding,
// the word returned to the pipeline when a bus access times out, and the
// default timeout length used by mem_access_unit / mem_access_timer.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Load result reported when the bus never answers.
   localparam logic [31:0] BUS_ERR_FILL = 32'hDEAD_BEEF;

   localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_access_timer.sv
// ---------------------------------------------------------------------------
// mem_access_timer
// Counts BUSY cycles that pass without a bus acknowledge and flags the cycle
// in which the TIMEOUT_CYCLES-th such cycle occurs. Only instantiated when
// MEM_ACCESS_TIMEOUT_EN is defined.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   a new access is being issued (clears the count)
//   busy     in   the access unit is waiting for the bus
//   ack      in   bus acknowledge for the current cycle
//   expired  out  this BUSY cycle is the last one allowed without ack
// ---------------------------------------------------------------------------
module mem_access_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic busy,
   input  logic ack,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   // Number of no-ack BUSY cycles already seen in the current access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= {CW{1'b0}};
      end else if (start) begin
         count <= {CW{1'b0}};
      end else if (busy && !ack) begin
         count <= count + CW'(1'b1);
      end else begin
         count <= count;
      end
   end

   // The current cycle would be the TIMEOUT_CYCLES-th one without an ack.
   assign expired = busy & ~ack & (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage responder: turns the load/store held in EX/MEM into a req/ack
// transaction on the data bus, stalls the pipeline while the bus is busy,
// returns registered load data and traps misaligned word accesses.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES BUSY cycles without ack (o_bus_err pulse, DEAD_BEEF data).
// Without it the unit waits for ack indefinitely and o_bus_err stays 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   i_mem_read/i_mem_write load / store request (both set = store)
//   i_addr, i_wdata       effective address and store data
//   bus_req/we/addr/wdata bus request and latched transaction fields
//   bus_rdata, bus_ack    read data and one-cycle completion strobe
//   o_stall               combinational pipeline freeze
//   o_read_data           last load result
//   o_done                one-cycle completion pulse
//   o_misaligned          one-cycle misaligned-trap pulse
//   o_bad_addr            address of the last trapped access
//   o_bus_err             one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic                  bus_ack,
   output logic                  o_stall,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic                  o_done,
   output logic                  o_misaligned,
   output logic [ADDR_WIDTH-1:0] o_bad_addr,
   output logic                  o_bus_err
);

   state_t                  state, state_nxt;
   logic                    access, aligned, issue, stall_cond, timeout_hit;
   logic                    req_nxt, we_nxt, done_nxt, mis_nxt, err_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt, bad_nxt;
   logic [DATA_WIDTH-1:0]   wdata_nxt, rdata_nxt;

   assign access  = i_mem_read | i_mem_write;
   assign aligned = (i_addr[1:0] == 2'b00);

`ifdef MEM_ACCESS_TIMEOUT_EN
   mem_access_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (issue),
      .busy    (state == ST_BUSY),
      .ack     (bus_ack),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Stall is gated by reset so every output reads 0 while reset is held.
   assign o_stall = reset & stall_cond;

   // Next-state and next-output logic; registered fields hold by default.
   always_comb begin
      state_nxt  = state;
      stall_cond = 1'b0;
      issue      = 1'b0;
      req_nxt    = bus_req;
      we_nxt     = bus_we;
      addr_nxt   = bus_addr;
      wdata_nxt  = bus_wdata;
      rdata_nxt  = o_read_data;
      bad_nxt    = o_bad_addr;
      done_nxt   = 1'b0;
      mis_nxt    = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (access && aligned) begin
               stall_cond = 1'b1;
               issue      = 1'b1;
               req_nxt    = 1'b1;
               we_nxt     = i_mem_write;
               addr_nxt   = i_addr;
               wdata_nxt  = i_wdata;
               state_nxt  = ST_BUSY;
            end else if (access) begin
               // Trapped: no bus activity, the store is dropped.
               mis_nxt = 1'b1;
               bad_nxt = i_addr;
            end else begin
               stall_cond = 1'b0;
            end
         end
         ST_BUSY: begin
            stall_cond = 1'b1;
            // An ack in the timeout cycle takes priority over the error.
            if (bus_ack) begin
               req_nxt   = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = ST_DONE;
               if (!bus_we) begin
                  rdata_nxt = bus_rdata;
               end else begin
                  rdata_nxt = o_read_data;
               end
            end else if (timeout_hit) begin
               req_nxt   = 1'b0;
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = ST_DONE;
               if (!bus_we) begin
                  rdata_nxt = DATA_WIDTH'(BUS_ERR_FILL);
               end else begin
                  rdata_nxt = o_read_data;
               end
            end else begin
               state_nxt = ST_BUSY;
            end
         end
         ST_DONE: begin
            // EX/MEM advances at this edge; the still-visible request
            // belongs to the access just completed and is not reissued.
            state_nxt = ST_IDLE;
         end
         default: begin
            req_nxt   = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= {ADDR_WIDTH{1'b0}};
         bus_wdata    <= {DATA_WIDTH{1'b0}};
         o_read_data  <= {DATA_WIDTH{1'b0}};
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         o_bad_addr   <= {ADDR_WIDTH{1'b0}};
         o_bus_err    <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus_req      <= req_nxt;
         bus_we       <= we_nxt;
         bus_addr     <= addr_nxt;
         bus_wdata    <= wdata_nxt;
         o_read_data  <= rdata_nxt;
         o_done       <= done_nxt;
         o_misaligned <= mis_nxt;
         o_bad_addr   <= bad_nxt;
         o_bus_err    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit: directed scenarios with literal
// expectations followed by randomized load/store traffic, all outputs
// compared every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int TMO = 4;
`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
   logic [31:0] i_addr = 32'h0, i_wdata = 32'h0;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_ack = 1'b0;
   logic        o_stall, o_done, o_misaligned, o_bus_err;
   logic [31:0] o_read_data, o_bad_addr;

   always #5 clk = ~clk;

   mem_access_unit #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_addr(i_addr), .i_wdata(i_wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .o_stall(o_stall), .o_read_data(o_read_data), .o_done(o_done),
      .o_misaligned(o_misaligned), .o_bad_addr(o_bad_addr),
      .o_bus_err(o_bus_err)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Observation counters for the directed scenarios.
   int cnt_req, cnt_we, cnt_stall, cnt_done, cnt_mis, cnt_err;

   task automatic clr_cnt();
      cnt_req = 0; cnt_we = 0; cnt_stall = 0; cnt_done = 0; cnt_mis = 0; cnt_err = 0;
   endtask

   // Reference model: expected register values for the current cycle.
   // m_req = a transaction is outstanding on the bus; m_cool = the cycle
   // right after completion, when the old request must not be reissued.
   logic        m_req, m_we, m_done, m_mis, m_berr, m_cool;
   logic [31:0] m_addr, m_wdata, m_rdata, m_bad;
   int          m_wait;

   always @(negedge clk) begin
      logic acc, algn, e_stall, n_done, n_mis, n_berr;
      if (!reset) begin
         m_req = 1'b0; m_we = 1'b0; m_done = 1'b0; m_mis = 1'b0; m_berr = 1'b0;
         m_cool = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
         m_bad = 32'h0; m_wait = 0;
      end else begin
         acc     = i_mem_read | i_mem_write;
         algn    = (i_addr[1:0] == 2'b00);
         e_stall = m_req | (!m_cool & acc & algn);
         chk("bus_req", {31'h0, bus_req}, {31'h0, m_req});
         chk("bus_we", {31'h0, bus_we}, {31'h0, m_we});
         chk("bus_addr", bus_addr, m_addr);
         chk("bus_wdata", bus_wdata, m_wdata);
         chk("o_stall", {31'h0, o_stall}, {31'h0, e_stall});
         chk("o_read_data", o_read_data, m_rdata);
         chk("o_done", {31'h0, o_done}, {31'h0, m_done});
         chk("o_misaligned", {31'h0, o_misaligned}, {31'h0, m_mis});
         chk("o_bad_addr", o_bad_addr, m_bad);
         chk("o_bus_err", {31'h0, o_bus_err}, {31'h0, m_berr});
         cnt_req   += int'(bus_req);
         cnt_we    += int'(bus_req & bus_we);
         cnt_stall += int'(o_stall);
         cnt_done  += int'(o_done);
         cnt_mis   += int'(o_misaligned);
         cnt_err   += int'(o_bus_err);
         // Advance the model with the inputs the DUT sees at the next edge.
         n_done = 1'b0; n_mis = 1'b0; n_berr = 1'b0;
         if (m_req) begin
            if (bus_ack) begin
               m_req = 1'b0; n_done = 1'b1; m_cool = 1'b1;
               if (!m_we) m_rdata = bus_rdata;
            end else if (TMO_EN && (m_wait + 1 == TMO)) begin
               m_req = 1'b0; n_done = 1'b1; n_berr = 1'b1; m_cool = 1'b1;
               if (!m_we) m_rdata = 32'hDEAD_BEEF;
            end else begin
               m_wait++;
            end
         end else if (m_cool) begin
            m_cool = 1'b0;
         end else if (acc && algn) begin
            m_req = 1'b1; m_we = i_mem_write; m_addr = i_addr; m_wdata = i_wdata; m_wait = 0;
         end else if (acc) begin
            n_mis = 1'b1; m_bad = i_addr;
         end
         m_done = n_done; m_mis = n_mis; m_berr = n_berr;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ack_val);
      repeat (n) begin
         bus_ack   = ack_val;
         bus_rdata = $urandom;
         step();
      end
      bus_ack = 1'b0;
   endtask

   // Present one EX/MEM request and act as pipeline + bus slave until the
   // pipeline advances. wait_n = no-ack BUSY cycles before ack (-1: never).
   task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int wait_n, input logic [31:0] rdat);
      int  waited = 0;
      int  n      = 0;
      bit  adv    = 1'b0;
      i_mem_read = rd; i_mem_write = wr; i_addr = a; i_wdata = d;
      while (!adv && n < 40) begin
         if (bus_req && waited == wait_n) begin
            bus_ack = 1'b1; bus_rdata = rdat;
         end else if (bus_req) begin
            bus_ack = 1'b0; bus_rdata = $urandom;
         end else begin
            // Stray acks while no request is out must be ignored.
            bus_ack = ($urandom_range(0, 3) == 0); bus_rdata = $urandom;
         end
         if (bus_req) waited++;
         #3;
         adv = !o_stall;
         step();
         n++;
      end
      if (!adv) chk("advance_timeout", 32'd0, 32'd1);
      i_mem_read = 1'b0; i_mem_write = 1'b0; bus_ack = 1'b0;
   endtask

   initial begin
      logic [31:0] ra;
      clr_cnt();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_bus_req", {31'h0, bus_req}, 32'd0);
      chk("reset_stall", {31'h0, o_stall}, 32'd0);
      chk("reset_read_data", o_read_data, 32'd0);
      chk("reset_bad_addr", o_bad_addr, 32'd0);
      reset = 1'b1;
      step();

      // Load, ack in 2nd BUSY cycle.
      clr_cnt();
      run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1234_5678);
      idle(2, 1'b0);
      chk("ld_req_cycles", cnt_req, 32'd2);
      chk("ld_we_cycles", cnt_we, 32'd0);
      chk("ld_stall_cycles", cnt_stall, 32'd3);
      chk("ld_done_pulses", cnt_done, 32'd1);
      chk("ld_data", o_read_data, 32'h1234_5678);

      // Store, immediate ack.
      clr_cnt();
      run_req(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'h5555_AAAA);
      idle(2, 1'b0);
      chk("st_req_cycles", cnt_req, 32'd1);
      chk("st_we_cycles", cnt_we, 32'd1);
      chk("st_stall_cycles", cnt_stall, 32'd2);
      chk("st_addr", bus_addr, 32'h0000_0020);
      chk("st_wdata", bus_wdata, 32'hCAFE_F00D);
      chk("st_read_data_kept", o_read_data, 32'h1234_5678);

      // Misaligned load.
      clr_cnt();
      run_req(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0);
      idle(2, 1'b0);
      chk("mis_req_cycles", cnt_req, 32'd0);
      chk("mis_pulses", cnt_mis, 32'd1);
      chk("mis_bad_addr", o_bad_addr, 32'h0000_0013);
      chk("mis_stall_cycles", cnt_stall, 32'd0);

      // Reset while BUSY.
      clr_cnt();
      i_mem_read = 1'b1; i_addr = 32'h0000_0040;
      step();
      step();
      chk("pre_rst_req", {31'h0, bus_req}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("rst_req_drop", {31'h0, bus_req}, 32'd0);
      chk("rst_stall_drop", {31'h0, o_stall}, 32'd0);
      i_mem_read = 1'b0; i_addr = 32'h0;
      @(posedge clk);
      #1 reset = 1'b1;
      idle(1, 1'b1);
      idle(1, 1'b0);
      chk("rst_no_done", cnt_done, 32'd0);
      chk("rst_read_data", o_read_data, 32'd0);
      run_req(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 32'hA5A5_0001);
      idle(1, 1'b0);
      chk("post_rst_load", o_read_data, 32'hA5A5_0001);

      // Spurious acks while idle.
      clr_cnt();
      idle(3, 1'b1);
      chk("spur_done", cnt_done, 32'd0);
      chk("spur_read_data", o_read_data, 32'hA5A5_0001);

`ifdef MEM_ACCESS_TIMEOUT_EN
      // Load that is never acknowledged.
      clr_cnt();
      run_req(1'b1, 1'b0, 32'h0000_0080, 32'h0, -1, 32'h0);
      idle(1, 1'b0);
      chk("tmo_req_cycles", cnt_req, 32'd4);
      chk("tmo_stall_cycles", cnt_stall, 32'd5);
      chk("tmo_err_pulses", cnt_err, 32'd1);
      chk("tmo_done_pulses", cnt_done, 32'd1);
      chk("tmo_data", o_read_data, 32'hDEAD_BEEF);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         int kind;
         kind = $urandom_range(0, 9);
         ra   = $urandom;
         if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
         if (kind < 4)       run_req(1'b1, 1'b0, ra, $urandom, $urandom_range(0, 5), $urandom);
         else if (kind < 7)  run_req(1'b0, 1'b1, ra, $urandom, $urandom_range(0, 5), $urandom);
         else if (kind < 8)  run_req(1'b1, 1'b1, ra, $urandom, $urandom_range(0, 5), $urandom);
         else                idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end
      idle(2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
